// File: rtl/pc_stack.sv
// Program counter with a return-address stack and sticky overflow/underflow flags.
// Latency: one cycle, op sampled on the edge and visible on out next cycle; no backpressure.
module pc_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             call,
    input  logic             ret,
    input  logic             err_clr,
    output logic [WIDTH-1:0] out,
    output logic [CNT_W-1:0] depth,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] out_q, out_d;
    logic [CNT_W-1:0] depth_q, depth_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic             push_en;
    logic [AW-1:0]    push_idx;
    logic [WIDTH-1:0] push_dat;
    logic [WIDTH-1:0] pc_plus1;

    assign full      = (depth_q == CNT_W'(DEPTH));
    assign empty     = (depth_q == '0);
    assign pc_plus1  = out_q + WIDTH'(1);

    always_comb begin
        out_d       = out_q;
        depth_d     = depth_q;
        // err_clr is applied first so that a same-edge error event overrides it
        overflow_d  = overflow_q & ~err_clr;
        underflow_d = underflow_q & ~err_clr;
        push_en     = 1'b0;
        push_idx    = AW'(depth_q);
        push_dat    = pc_plus1;

        if (clear) begin
            out_d       = '0;
            depth_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (call && ret) begin
            out_d = in;
        end else if (call) begin
            out_d = in;
            if (!full) begin
                push_en = 1'b1;
                depth_d = depth_q + CNT_W'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end else if (ret) begin
            if (!empty) begin
                out_d   = stack_mem[AW'(depth_q - CNT_W'(1))];
                depth_d = depth_q - CNT_W'(1);
            end else begin
                underflow_d = 1'b1;
            end
        end else if (load) begin
            out_d = in;
        end else if (inc) begin
            out_d = pc_plus1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q       <= '0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Stack storage carries no reset; entries above depth are never read.
    always_ff @(posedge clock) begin
        if (push_en) begin
            stack_mem[push_idx] <= push_dat;
        end
    end

    assign out       = out_q;
    assign depth     = depth_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack (WIDTH=16, DEPTH=4) with a queue-based reference model.
module tb_pc_stack;
    localparam int W = 16;
    localparam int D = 4;
    localparam int CW = $clog2(D + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic [W-1:0]  din = '0;
    logic          load = 1'b0;
    logic          inc = 1'b0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic          err_clr = 1'b0;
    logic [W-1:0]  dout;
    logic [CW-1:0] depth;
    logic          full, empty, overflow, underflow;

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    logic [W-1:0] m_stack [$];
    logic [W-1:0] m_out = '0;
    bit           m_ovf = 1'b0;
    bit           m_unf = 1'b0;

    pc_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clock(clock), .reset(reset), .clear(clear), .in(din),
        .load(load), .inc(inc), .call(call), .ret(ret), .err_clr(err_clr),
        .out(dout), .depth(depth), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (started) begin
            chk("model.out", int'(dout), int'(m_out));
            chk("model.depth", int'(depth), m_stack.size());
            chk("model.full", int'(full), int'(m_stack.size() == D));
            chk("model.empty", int'(empty), int'(m_stack.size() == 0));
            chk("model.overflow", int'(overflow), int'(m_ovf));
            chk("model.underflow", int'(underflow), int'(m_unf));
        end
    end

    task automatic model_reset();
        m_stack.delete();
        m_out = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic step(input bit c_clr, input bit c_ld, input bit c_inc, input bit c_call,
                        input bit c_ret, input bit c_ec, input logic [W-1:0] c_in);
        @(negedge clock);
        clear = c_clr; load = c_ld; inc = c_inc; call = c_call; ret = c_ret;
        err_clr = c_ec; din = c_in;
        @(posedge clock);
        if (c_clr) begin
            model_reset();
        end else begin
            if (c_ec) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (c_call && c_ret) begin
                m_out = c_in;
            end else if (c_call) begin
                if (m_stack.size() < D) m_stack.push_back(m_out + 16'd1);
                else m_ovf = 1'b1;
                m_out = c_in;
            end else if (c_ret) begin
                if (m_stack.size() > 0) m_out = m_stack.pop_back();
                else m_unf = 1'b1;
            end else if (c_ld) begin
                m_out = c_in;
            end else if (c_inc) begin
                m_out = m_out + 16'd1;
            end
        end
        #1;
        clear = 0; load = 0; inc = 0; call = 0; ret = 0; err_clr = 0;
    endtask

    task automatic do_load(input logic [W-1:0] v); step(0, 1, 0, 0, 0, 0, v); endtask
    task automatic do_call(input logic [W-1:0] v); step(0, 0, 0, 1, 0, 0, v); endtask
    task automatic do_ret();                       step(0, 0, 0, 0, 1, 0, '0); endtask

    initial begin
        #2;
        chk("reset.out", int'(dout), 0);
        chk("reset.depth", int'(depth), 0);
        chk("reset.empty", int'(empty), 1);
        #10 reset = 1'b1;
        started = 1'b1;

        // async reset mid-cycle
        do_load(16'h1234);
        chk("load.1234", int'(dout), 'h1234);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("areset.out", int'(dout), 0);
        chk("areset.depth", int'(depth), 0);
        chk("areset.flags", int'({overflow, underflow}), 0);
        #2 reset = 1'b1;

        // synchronous clear with a populated stack
        do_call(16'h0020);
        do_call(16'h0050);
        chk("preclr.out", int'(dout), 'h50);
        chk("preclr.depth", int'(depth), 2);
        step(1, 0, 0, 0, 0, 0, '0);
        chk("clear.out", int'(dout), 0);
        chk("clear.depth", int'(depth), 0);
        chk("clear.empty", int'(empty), 1);

        // load / inc wrap / load beats inc
        do_load(16'hFFFF);
        chk("load.ffff", int'(dout), 'hFFFF);
        step(0, 0, 1, 0, 0, 0, '0);
        chk("inc.wrap", int'(dout), 0);
        step(0, 1, 1, 0, 0, 0, 16'h0200);
        chk("load_inc", int'(dout), 'h200);

        // nested call / return
        do_load(16'h0010);
        do_call(16'h0100);
        chk("call1.out", int'(dout), 'h100);
        chk("call1.depth", int'(depth), 1);
        do_call(16'h0200);
        chk("call2.out", int'(dout), 'h200);
        do_ret();
        chk("ret1.out", int'(dout), 'h101);
        do_ret();
        chk("ret2.out", int'(dout), 'h11);
        chk("ret2.empty", int'(empty), 1);

        // overflow: fifth call's return address is discarded
        do_load(16'h0000);
        do_call(16'h0010); do_call(16'h0020); do_call(16'h0030); do_call(16'h0040);
        chk("ovf.full", int'(full), 1);
        do_call(16'h0050);
        chk("ovf.out", int'(dout), 'h50);
        chk("ovf.depth", int'(depth), 4);
        chk("ovf.flag", int'(overflow), 1);
        do_ret(); chk("ovf.ret1", int'(dout), 'h31);
        do_ret(); chk("ovf.ret2", int'(dout), 'h21);
        do_ret(); chk("ovf.ret3", int'(dout), 'h11);
        do_ret(); chk("ovf.ret4", int'(dout), 'h01);
        chk("ovf.sticky", int'(overflow), 1);
        step(0, 0, 0, 0, 0, 1, '0);
        chk("ovf.errclr", int'(overflow), 0);

        // underflow and err_clr priority
        do_load(16'h0123);
        do_ret();
        chk("unf.out", int'(dout), 'h123);
        chk("unf.flag", int'(underflow), 1);
        step(0, 0, 0, 0, 0, 1, '0);
        chk("unf.clr", int'(underflow), 0);
        step(0, 0, 0, 0, 1, 1, '0);
        chk("unf.set_wins", int'(underflow), 1);

        // tail jump: call+ret cancel
        do_load(16'h0030);
        do_call(16'h0100);
        step(0, 0, 0, 1, 1, 0, 16'h0400);
        chk("tail.out", int'(dout), 'h400);
        chk("tail.depth", int'(depth), 1);
        do_ret();
        chk("tail.ret", int'(dout), 'h31);

        // pushed return address wraps modulo 2^16
        do_load(16'hFFFF);
        do_call(16'h0005);
        do_ret();
        chk("push.wrap", int'(dout), 0);

        // reset with live stack entries empties it
        do_call(16'h0070);
        do_call(16'h0080);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("areset2.depth", int'(depth), 0);
        #2 reset = 1'b1;
        do_ret();
        chk("areset2.unf", int'(underflow), 1);

        repeat (2) @(posedge clock);
        #1;
        started = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
